// File: rtl/cheby_out_packer.sv
// Output packer: pairs 16-bit samples into 32-bit words and stages them
// in a small queue ahead of the output FIFO, flushing lone halves on idle.
module cheby_out_packer #(
    parameter int          DEPTH        = 8,
    parameter int          FLUSH_CYCLES = 64,
    parameter logic [15:0] PAD          = 16'h0000
) (
    input  logic        bus_clk,
    input  logic        user_r_read_32_open,
    input  logic [15:0] din,
    input  logic        din_v,
    input  logic        flush,
    output logic [31:0] fifo_din,
    output logic        fifo_wr_en,
    input  logic        fifo_full,
    output logic        pending,
    output logic        overflow,
    output logic [31:0] word_cnt,
    output logic [15:0] pad_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int IW = $clog2(FLUSH_CYCLES) + 1;
    localparam logic [IW-1:0] IDLE_MAX = IW'(FLUSH_CYCLES - 1);

    logic [31:0]   r_mem [DEPTH];
    logic [AW:0]   r_wp;
    logic [AW:0]   r_rp;
    logic [15:0]   r_lo;
    logic          r_pend;
    logic [IW-1:0] r_idle;
    logic          r_ovf;
    logic [31:0]   r_wcnt;
    logic [15:0]   r_pcnt;

    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_pair;
    logic          w_pad;
    logic          w_push;
    logic          w_accept;
    logic [31:0]   w_word;

    assign w_empty  = (r_wp == r_rp);
    assign w_full   = (r_wp[AW] != r_rp[AW]) &&
                      (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_pop    = !w_empty && !fifo_full;
    assign w_pair   = din_v && r_pend;
    // din_v wins over flush/timeout: the held half always pairs first
    assign w_pad    = !din_v && r_pend && (flush || r_idle == IDLE_MAX);
    assign w_push   = w_pair || w_pad;
    assign w_word   = w_pair ? {din, r_lo} : {PAD, r_lo};
    assign w_accept = w_push && (!w_full || w_pop);

    assign fifo_wr_en = w_pop;
    assign fifo_din   = w_empty ? 32'h0 : r_mem[r_rp[AW-1:0]];
    assign pending    = r_pend;
    assign overflow   = r_ovf;
    assign word_cnt   = r_wcnt;
    assign pad_cnt    = r_pcnt;

    always_ff @(posedge bus_clk) begin
        if (user_r_read_32_open && w_accept) begin
            r_mem[r_wp[AW-1:0]] <= w_word;
        end
    end

    always_ff @(posedge bus_clk) begin
        if (!user_r_read_32_open) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_lo   <= '0;
            r_pend <= 1'b0;
            r_idle <= '0;
            r_ovf  <= 1'b0;
            r_wcnt <= '0;
            r_pcnt <= '0;
        end else begin
            if (din_v) begin
                r_pend <= !r_pend;
                if (!r_pend) begin
                    r_lo <= din;
                end
            end else if (w_pad) begin
                r_pend <= 1'b0;
            end

            if (din_v || !r_pend || w_pad) begin
                r_idle <= '0;
            end else begin
                r_idle <= r_idle + 1'b1;
            end

            if (w_pad && r_pcnt != 16'hFFFF) begin
                r_pcnt <= r_pcnt + 16'd1;
            end

            if (w_pop) begin
                r_rp   <= r_rp + 1'b1;
                r_wcnt <= r_wcnt + 32'd1;
            end

            if (w_accept) begin
                r_wp <= r_wp + 1'b1;
            end else if (w_push) begin
                r_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cheby_out_packer.sv
// Bench for cheby_out_packer: directed scenarios plus random traffic,
// checked every cycle against a queue-based model of the packer.
module tb_cheby_out_packer;

    localparam int DEPTH = 4;
    localparam int FLUSH_CYCLES = 6;

    logic        bus_clk = 1'b0;
    logic        open = 1'b0;
    logic [15:0] din = '0;
    logic        din_v = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] fifo_din;
    logic        fifo_wr_en;
    logic        fifo_full = 1'b0;
    logic        pending;
    logic        overflow;
    logic [31:0] word_cnt;
    logic [15:0] pad_cnt;

    int vectors = 0;
    int fails = 0;

    cheby_out_packer #(
        .DEPTH(DEPTH),
        .FLUSH_CYCLES(FLUSH_CYCLES),
        .PAD(16'h0000)
    ) dut (
        .bus_clk(bus_clk),
        .user_r_read_32_open(open),
        .din(din),
        .din_v(din_v),
        .flush(flush),
        .fifo_din(fifo_din),
        .fifo_wr_en(fifo_wr_en),
        .fifo_full(fifo_full),
        .pending(pending),
        .overflow(overflow),
        .word_cnt(word_cnt),
        .pad_cnt(pad_cnt)
    );

    always #5 bus_clk = ~bus_clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a word queue, one held half, and an idle-edge count.
    logic [31:0] mq[$];
    logic        m_valid = 1'b0;
    logic        m_pend;
    logic [15:0] m_lo;
    int          m_idle;
    logic        m_ovf;
    logic [31:0] m_wc;
    logic [15:0] m_pc;

    always @(posedge bus_clk) begin
        bit          pop;
        bit          push;
        bit          padw;
        logic [31:0] w;
        if (!open) begin
            mq.delete();
            m_pend = 0; m_lo = 0; m_idle = 0;
            m_ovf = 0; m_wc = 0; m_pc = 0;
            m_valid = 1;
        end else if (m_valid) begin
            pop = (mq.size() > 0) && !fifo_full;
            push = 0; padw = 0; w = '0;
            if (din_v) begin
                if (m_pend) begin
                    push = 1; w = {din, m_lo}; m_pend = 0;
                end else begin
                    m_lo = din; m_pend = 1;
                end
                m_idle = 0;
            end else if (m_pend) begin
                m_idle++;
                if (flush || m_idle == FLUSH_CYCLES) begin
                    push = 1; padw = 1; w = {16'h0000, m_lo};
                    m_pend = 0; m_idle = 0;
                end
            end
            if (pop) begin
                void'(mq.pop_front());
                m_wc++;
            end
            if (push) begin
                if (mq.size() < DEPTH) mq.push_back(w);
                else m_ovf = 1;
            end
            if (padw && m_pc != 16'hFFFF) m_pc++;
        end
    end

    always @(negedge bus_clk) begin
        if (m_valid) begin
            chk("wr_en", {31'b0, fifo_wr_en},
                {31'b0, (mq.size() > 0) && !fifo_full});
            chk("fifo_din", fifo_din, (mq.size() > 0) ? mq[0] : 32'h0);
            chk("pending", {31'b0, pending}, {31'b0, m_pend});
            chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
            chk("word_cnt", word_cnt, m_wc);
            chk("pad_cnt", {16'b0, pad_cnt}, {16'b0, m_pc});
        end
    end

    task automatic tick(input logic v, input logic [15:0] d,
                        input logic f, input logic full, input logic op);
        din_v = v; din = d; flush = f; fifo_full = full; open = op;
        @(posedge bus_clk);
        #1;
    endtask

    initial begin
        // reset held with din_v active
        repeat (3) tick(1, 16'h5A5A, 0, 0, 0);
        @(negedge bus_clk);
        chk("rst_wr_en", {31'b0, fifo_wr_en}, 32'd0);
        chk("rst_pending", {31'b0, pending}, 32'd0);
        chk("rst_word_cnt", word_cnt, 32'd0);
        chk("rst_overflow", {31'b0, overflow}, 32'd0);

        // pairing
        tick(1, 16'h1111, 0, 0, 1);
        tick(1, 16'h2222, 0, 0, 1);
        @(negedge bus_clk);
        chk("pair_wr_en", {31'b0, fifo_wr_en}, 32'd1);
        chk("pair_word", fifo_din, 32'h2222_1111);
        tick(0, 0, 0, 0, 1);
        @(negedge bus_clk);
        chk("pair_cnt", word_cnt, 32'd1);

        // idle timeout
        tick(1, 16'hABCD, 0, 0, 1);
        repeat (FLUSH_CYCLES - 1) tick(0, 0, 0, 0, 1);
        @(negedge bus_clk);
        chk("tmo_early_pend", {31'b0, pending}, 32'd1);
        tick(0, 0, 0, 0, 1);
        @(negedge bus_clk);
        chk("tmo_word", fifo_din, 32'h0000_ABCD);
        chk("tmo_pad_cnt", {16'b0, pad_cnt}, 32'd1);
        chk("tmo_pending", {31'b0, pending}, 32'd0);
        tick(0, 0, 0, 0, 1);

        // explicit flush
        tick(1, 16'h7777, 0, 0, 1);
        tick(0, 0, 1, 0, 1);
        @(negedge bus_clk);
        chk("flush_word", fifo_din, 32'h0000_7777);
        tick(0, 0, 0, 0, 1);

        // backpressure fill, then overflow, then drain
        for (int i = 0; i < 2 * DEPTH; i++)
            tick(1, 16'(16'h0100 + i), 0, 1, 1);
        @(negedge bus_clk);
        chk("bp_no_ovf", {31'b0, overflow}, 32'd0);
        tick(1, 16'hEEE0, 0, 1, 1);
        tick(1, 16'hEEE1, 0, 1, 1);
        @(negedge bus_clk);
        chk("bp_ovf", {31'b0, overflow}, 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge bus_clk);
            chk("bp_drain", fifo_din,
                {16'(16'h0101 + 2 * i), 16'(16'h0100 + 2 * i)});
            tick(0, 0, 0, 0, 1);
        end
        tick(0, 0, 0, 0, 0);

        // flush collides with din_v
        tick(1, 16'h0001, 0, 0, 1);
        tick(1, 16'h0002, 1, 0, 1);
        @(negedge bus_clk);
        chk("fvd_word", fifo_din, 32'h0002_0001);
        chk("fvd_pad_cnt", {16'b0, pad_cnt}, 32'd0);
        tick(0, 0, 0, 0, 1);

        // mid-operation reset
        for (int i = 0; i < 7; i++) tick(1, 16'(16'hC000 + i), 0, 1, 1);
        tick(0, 0, 0, 1, 0);
        @(negedge bus_clk);
        chk("mrst_pending", {31'b0, pending}, 32'd0);
        chk("mrst_wr_en", {31'b0, fifo_wr_en}, 32'd0);
        tick(1, 16'h0A0A, 0, 0, 1);
        tick(1, 16'h0B0B, 0, 0, 1);
        @(negedge bus_clk);
        chk("mrst_word", fifo_din, 32'h0B0B_0A0A);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            tick($urandom_range(0, 9) < 7, 16'($urandom),
                 $urandom_range(0, 9) == 0,
                 (i % 200 < 60) ? 1'b1 : ($urandom_range(0, 9) < 3),
                 $urandom_range(0, 499) != 0);
        end
        repeat (2 * FLUSH_CYCLES) tick(0, 0, 0, 0, 1);
        @(negedge bus_clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
